traffic_light_ctrl_timed: RTL

Parametrised two-road traffic light controller, successor to the fixed single-sequence controller. It drives main-road and side-road lamp sets with per-phase durations set by parameters, and latches side-road car requests. It adds an emergency override that brings every lamp to red safely. The block sits in the lab FSM directory as the DUT for the next-generation testbench.

---
 rtl/traffic_light_ctrl_timed.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/traffic_light_ctrl_timed.sv
// traffic_light_ctrl_timed
//   Two-road traffic light controller with parameterised phase durations,
//   a latched side-road request and an emergency override that walks the
//   junction to all-red through the yellow phases.
//
// Ports
//   clock_i         system clock, all state changes on its rising edge
//   reset_i         asynchronous active-high reset (back to MAIN_GREEN)
//   car_i           side-road car sensor, sampled on rising edges
//   emergency_i     level-sensitive emergency override request
//   main_red_o, main_yellow_o, main_green_o   main-road lamps
//   side_red_o, side_yellow_o, side_green_o   side-road lamps
//   emerg_active_o  high while the controller sits in EMERG
module traffic_light_ctrl_timed #(
  parameter int unsigned GREEN_MIN         = 4,
  parameter int unsigned YELLOW_CYCLES     = 2,
  parameter int unsigned ALL_RED_CYCLES    = 1,
  parameter int unsigned SIDE_GREEN_CYCLES = 3,
  parameter int unsigned CNT_W             = 8
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic car_i,
  input  logic emergency_i,
  output logic main_red_o,
  output logic main_yellow_o,
  output logic main_green_o,
  output logic side_red_o,
  output logic side_yellow_o,
  output logic side_green_o,
  output logic emerg_active_o
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5,
    EMERG       = 3'd6
  } state_e;

  // Last count value of each timed phase; a phase of N cycles ends when cnt
  // reaches N-1 because cnt starts at zero on the entry edge.
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALL_RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] SIDE_LAST   = CNT_W'(SIDE_GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              req;

  assign req = car_i | pend_q;

  // State, phase counter and request latch all reset asynchronously so the
  // lamps return to main-green the moment reset rises.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= MAIN_GREEN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic. Emergency forces greens into their yellow at once,
  // lets a yellow finish and then diverts it to EMERG, and pulls the all-red
  // phases straight into EMERG. Inside EMERG the counter only advances on
  // cycles where emergency is low, so it measures the release countdown.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MAIN_GREEN: begin
        if (emergency_i || (req && (cnt_q >= GREEN_LAST)))
          state_d = MAIN_YELLOW;
      end
      MAIN_YELLOW: begin
        if (cnt_q == YELLOW_LAST)
          state_d = emergency_i ? EMERG : ALL_RED_A;
      end
      ALL_RED_A: begin
        if (emergency_i)
          state_d = EMERG;
        else if (cnt_q == ALLRED_LAST)
          state_d = SIDE_GREEN;
      end
      SIDE_GREEN: begin
        if (emergency_i || (cnt_q == SIDE_LAST))
          state_d = SIDE_YELLOW;
      end
      SIDE_YELLOW: begin
        if (cnt_q == YELLOW_LAST)
          state_d = emergency_i ? EMERG : ALL_RED_B;
      end
      ALL_RED_B: begin
        if (emergency_i)
          state_d = EMERG;
        else if (cnt_q == ALLRED_LAST)
          state_d = MAIN_GREEN;
      end
      EMERG: begin
        if (!emergency_i && (cnt_q == ALLRED_LAST))
          state_d = MAIN_GREEN;
      end
      default: state_d = MAIN_GREEN;
    endcase
  end

  // Counter clears on any transition and on emergency re-assertion inside
  // EMERG, otherwise counts up and saturates. The request latch clears on
  // the edge entering SIDE_GREEN, taking priority over a car on that edge.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q | car_i;
    if (state_d != state_q)
      cnt_d = '0;
    else if ((state_q == EMERG) && emergency_i)
      cnt_d = '0;
    else if (cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_ONE;
    if ((state_d == SIDE_GREEN) && (state_q != SIDE_GREEN))
      pend_d = 1'b0;
  end

  // Moore lamp decode, exactly one lamp per road in every state.
  always_comb begin
    main_red_o     = 1'b0;
    main_yellow_o  = 1'b0;
    main_green_o   = 1'b0;
    side_red_o     = 1'b0;
    side_yellow_o  = 1'b0;
    side_green_o   = 1'b0;
    emerg_active_o = 1'b0;
    case (state_q)
      MAIN_GREEN: begin
        main_green_o = 1'b1;
        side_red_o   = 1'b1;
      end
      MAIN_YELLOW: begin
        main_yellow_o = 1'b1;
        side_red_o    = 1'b1;
      end
      SIDE_GREEN: begin
        main_red_o   = 1'b1;
        side_green_o = 1'b1;
      end
      SIDE_YELLOW: begin
        main_red_o    = 1'b1;
        side_yellow_o = 1'b1;
      end
      EMERG: begin
        main_red_o     = 1'b1;
        side_red_o     = 1'b1;
        emerg_active_o = 1'b1;
      end
      default: begin
        main_red_o = 1'b1;
        side_red_o = 1'b1;
      end
    endcase
  end

endmodule
